// File: rtl/conv16_sched_pkg.sv
// rtl/conv16_sched_pkg.sv - shared widths and FSM state type for the conv16 sequencer
package conv16_sched_pkg;

  localparam int conv16_width     = 8;
  localparam int CONV16_LANES     = 8;
  localparam int CONV16_SUM_W     = 2 * conv16_width;
  // Four guard bits cover sixteen accumulated full-scale sums without wrap.
  localparam int CONV16_ACC_GUARD = 4;
  localparam int CONV16_ACC_W     = CONV16_SUM_W + CONV16_ACC_GUARD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RUN   = 3'd2,
    ST_ACC   = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/conv16_sched_if.sv
// rtl/conv16_sched_if.sv - fetch, core and output-row signal bundle for conv16_sched
interface conv16_sched_if
  import conv16_sched_pkg::*;
#(
  parameter int ACC_W = CONV16_ACC_W
);

  logic                                        fetch_req;
  logic                                        fetch_ack;
  logic [3:0]                                  ci_idx;
  logic [5:0]                                  co_idx;
  logic                                        core_en;
  logic                                        core_end;
  logic [CONV16_LANES-1:0][CONV16_SUM_W-1:0]   core_sum;
  logic                                        o_valid;
  logic                                        o_ready;
  logic [5:0]                                  o_co;
  logic [CONV16_LANES-1:0][ACC_W-1:0]          o_data;

  modport master (
    output fetch_req, ci_idx, co_idx, core_en, o_valid, o_co, o_data,
    input  fetch_ack, core_end, core_sum, o_ready
  );

  modport slave (
    input  fetch_req, ci_idx, co_idx, core_en, o_valid, o_co, o_data,
    output fetch_ack, core_end, core_sum, o_ready
  );

endinterface

// File: rtl/conv16_sched_acc8.sv
// rtl/conv16_sched_acc8.sv - eight-lane capture and sign-extending accumulator bank
module conv16_acc8
  import conv16_sched_pkg::*;
#(
  parameter int SUM_W = CONV16_SUM_W,
  parameter int ACC_W = CONV16_ACC_W
) (
  input  logic                                  clk_i,
  input  logic                                  resetn_i,
  input  logic                                  clear_i,
  input  logic                                  capture_i,
  input  logic                                  clear_load_i,
  input  logic                                  add_en_i,
  input  logic [CONV16_LANES-1:0][SUM_W-1:0]    sum_i,
  output logic [CONV16_LANES-1:0][ACC_W-1:0]    acc_o
);

  logic [CONV16_LANES-1:0][SUM_W-1:0] cap_q, cap_d;
  logic [CONV16_LANES-1:0][ACC_W-1:0] acc_q, acc_d;

  function automatic logic [ACC_W-1:0] sext(input logic [SUM_W-1:0] v);
    return {{(ACC_W - SUM_W){v[SUM_W-1]}}, v};
  endfunction

  // Accumulation reads the capture bank, so the add lands one edge after core_end.
  always_comb begin
    cap_d = capture_i ? sum_i : cap_q;
    acc_d = acc_q;
    for (int k = 0; k < CONV16_LANES; k++) begin
      if (clear_load_i) begin
        acc_d[k] = sext(cap_q[k]);
      end else if (add_en_i) begin
        acc_d[k] = acc_q[k] + sext(cap_q[k]);
      end
    end
    if (clear_i) begin
      cap_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cap_q <= '0;
      acc_q <= '0;
    end else begin
      cap_q <= cap_d;
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv16_sched.sv
// rtl/conv16_sched.sv - per-output-channel pass sequencer accumulating conv16 partial sums
module conv16_sched
  import conv16_sched_pkg::*;
#(
  parameter int CIN   = 3,
  parameter int COUT  = 16,
  parameter int ACC_W = CONV16_ACC_W
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  conv16_sched_if.master        bus
);

  localparam logic [3:0] CI_LAST = 4'(CIN - 1);
  localparam logic [5:0] CO_LAST = 6'(COUT - 1);

  sched_state_e state_q, state_d;
  logic [3:0]   ci_q, ci_d;
  logic [5:0]   co_q, co_d;
  logic         capture;
  logic         clear_load;
  logic         add_en;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      ci_q    <= '0;
      co_q    <= '0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      co_q    <= co_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ci_d       = ci_q;
    co_d       = co_q;
    capture    = 1'b0;
    clear_load = 1'b0;
    add_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
          ci_d    = '0;
          co_d    = '0;
        end
      end
      ST_FETCH: begin
        if (bus.fetch_ack) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.core_end) begin
          capture = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        clear_load = (ci_q == 4'd0);
        add_en     = (ci_q != 4'd0);
        if (ci_q != CI_LAST) begin
          ci_d    = ci_q + 4'd1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.o_ready) begin
          if (co_q == CO_LAST) begin
            state_d = ST_DONE;
          end else begin
            co_d    = co_q + 6'd1;
            ci_d    = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Cancel wins over every transition, including a start seen in IDLE.
    if (abort_i) begin
      state_d    = ST_IDLE;
      ci_d       = '0;
      co_d       = '0;
      capture    = 1'b0;
      clear_load = 1'b0;
      add_en     = 1'b0;
    end
  end

  conv16_acc8 #(
    .SUM_W (CONV16_SUM_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .clear_i      (abort_i),
    .capture_i    (capture),
    .clear_load_i (clear_load),
    .add_en_i     (add_en),
    .sum_i        (bus.core_sum),
    .acc_o        (bus.o_data)
  );

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign bus.fetch_req = (state_q == ST_FETCH);
  assign bus.core_en   = (state_q == ST_RUN);
  assign bus.o_valid   = (state_q == ST_OUT);
  assign bus.ci_idx    = ci_q;
  assign bus.co_idx    = co_q;
  assign bus.o_co      = co_q;

endmodule

// File: tb/tb_conv16_sched.sv
// tb/tb_conv16_sched.sv - directed self-checking bench for conv16_sched
module tb_conv16_sched;
  import conv16_sched_pkg::*;

  localparam int SW = CONV16_SUM_W;
  localparam int AW = CONV16_ACC_W;
  typedef logic [7:0][SW-1:0] sums_t;
  typedef logic [7:0][AW-1:0] accs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, start, abort, fetch_ack, core_end, o_ready;
  logic [1:0] sel;
  sums_t      core_sum;

  logic [2:0] busy_v, done_v, freq_v, cen_v, oval_v;
  logic [3:0] ci_v  [3];
  logic [5:0] co_v  [3];
  logic [5:0] oco_v [3];
  accs_t      odat_v[3];

  // Instance 0: CIN=3 COUT=2, instance 1: CIN=16 COUT=1, instance 2: CIN=1 COUT=1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv16_sched_if bus ();
    conv16_sched #(
      .CIN  (g == 0 ? 3 : (g == 1 ? 16 : 1)),
      .COUT (g == 0 ? 2 : 1)
    ) dut (
      .clk_i    (clk),
      .resetn_i (rstn),
      .start_i  (start && (sel == 2'(g))),
      .abort_i  (abort && (sel == 2'(g))),
      .busy_o   (busy_v[g]),
      .done_o   (done_v[g]),
      .bus      (bus)
    );
    assign bus.fetch_ack = fetch_ack && (sel == 2'(g));
    assign bus.core_end  = core_end && (sel == 2'(g));
    assign bus.core_sum  = core_sum;
    assign bus.o_ready   = o_ready && (sel == 2'(g));
    assign freq_v[g]     = bus.fetch_req;
    assign cen_v[g]      = bus.core_en;
    assign oval_v[g]     = bus.o_valid;
    assign ci_v[g]       = bus.ci_idx;
    assign co_v[g]       = bus.co_idx;
    assign oco_v[g]      = bus.o_co;
    assign odat_v[g]     = bus.o_data;
  end

  logic busy, done, fetch_req, core_en, o_valid;
  logic [3:0] ci_idx;
  logic [5:0] co_idx, o_co;
  accs_t o_data;
  assign busy      = busy_v[sel];
  assign done      = done_v[sel];
  assign fetch_req = freq_v[sel];
  assign core_en   = cen_v[sel];
  assign o_valid   = oval_v[sel];
  assign ci_idx    = ci_v[sel];
  assign co_idx    = co_v[sel];
  assign o_co      = oco_v[sel];
  assign o_data    = odat_v[sel];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sums_t sums_mul(input int m);
    sums_t r;
    for (int k = 0; k < 8; k++) r[k] = SW'((k + 1) * m);
    return r;
  endfunction

  function automatic accs_t accs_mul(input int m);
    accs_t r;
    for (int k = 0; k < 8; k++) r[k] = AW'((k + 1) * m);
    return r;
  endfunction

  task automatic do_pass(input sums_t s, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 40 && !fetch_req; i++) tick();
    if (!fetch_req) ok = 1'b0;
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    if (!core_en) ok = 1'b0;
    core_sum = s;
    core_end = 1'b1;
    tick();
    core_end = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    sel = 2'd0; start = 0; abort = 0; fetch_ack = 0; core_end = 0; o_ready = 0;
    core_sum = '0; rstn = 1'b0;
    tick(); tick();
    n_checks++; if (busy_v !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b want 000", busy_v); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if ({fetch_req, core_en, o_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000", {fetch_req, core_en, o_valid}); end
    n_checks++; if ({ci_idx, co_idx, o_co} !== 16'h0) begin n_fail++; $display("FAIL reset_idx: got %h want 0", {ci_idx, co_idx, o_co}); end
    n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_accumulate();
    bit ok;
    accs_t exp6 = accs_mul(6);
    sel = 2'd0; o_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if ({fetch_req, busy, ci_idx, co_idx} !== {1'b1, 1'b1, 4'd0, 6'd0}) begin n_fail++; $display("FAIL acc_start: got req=%b busy=%b ci=%0d co=%0d want 1 1 0 0", fetch_req, busy, ci_idx, co_idx); end
    for (int co = 0; co < 2; co++) begin
      do_pass(sums_mul(1), ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL acc_pass1_co%0d: handshake timeout", co); end
      do_pass(sums_mul(10), ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL acc_pass2_co%0d: handshake timeout", co); end
      do_pass(sums_mul(-5), ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL acc_pass3_co%0d: handshake timeout", co); end
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL acc_valid_co%0d: got %b want 1", co, o_valid); end
      n_checks++; if (o_co !== 6'(co)) begin n_fail++; $display("FAIL acc_oco: got %0d want %0d", o_co, co); end
      for (int k = 0; k < 8; k++) begin
        n_checks++; if (o_data[k] !== exp6[k]) begin n_fail++; $display("FAIL acc_lane%0d_co%0d: got %h want %h", k + 1, co, o_data[k], exp6[k]); end
      end
      tick();
      if (co == 0) begin
        n_checks++; if ({fetch_req, co_idx, ci_idx} !== {1'b1, 6'd1, 4'd0}) begin n_fail++; $display("FAIL acc_next_co: got req=%b co=%0d ci=%0d want 1 1 0", fetch_req, co_idx, ci_idx); end
      end
    end
    n_checks++; if ({done, busy} !== 2'b11) begin n_fail++; $display("FAIL acc_done: got done=%b busy=%b want 1 1", done, busy); end
    tick();
    n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL acc_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_extreme();
    bit    ok;
    bit    all_ok = 1'b1;
    sums_t s;
    accs_t e;
    sel = 2'd1; o_ready = 1'b1;
    s[0] = 16'h8000; e[0] = 20'h80000;
    s[1] = 16'h7FFF; e[1] = 20'h7FFF0;
    s[2] = 16'hFFFF; e[2] = 20'hFFFF0;
    s[3] = 16'h0001; e[3] = 20'h00010;
    s[4] = 16'hC000; e[4] = 20'hC0000;
    s[5] = 16'h4000; e[5] = 20'h40000;
    s[6] = 16'h8001; e[6] = 20'h80010;
    s[7] = 16'h0000; e[7] = 20'h00000;
    start = 1'b1; tick(); start = 1'b0;
    for (int p = 0; p < 16; p++) begin
      do_pass(s, ok);
      all_ok &= ok;
    end
    n_checks++; if (!all_ok) begin n_fail++; $display("FAIL ext_passes: handshake timeout"); end
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ext_valid: got %b want 1", o_valid); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (o_data[k] !== e[k]) begin n_fail++; $display("FAIL ext_lane%0d: got %h want %h", k + 1, o_data[k], e[k]); end
    end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ext_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    accs_t exp6 = accs_mul(6);
    sel = 2'd0; o_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    do_pass(sums_mul(1), ok);
    do_pass(sums_mul(10), ok);
    do_pass(sums_mul(-5), ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_pass: handshake timeout"); end
    for (int i = 0; i < 20; i++) begin
      n_checks++; if ({o_valid, fetch_req, core_en} !== 3'b100) begin n_fail++; $display("FAIL bp_ctrl_c%0d: got valid/req/en=%b want 100", i, {o_valid, fetch_req, core_en}); end
      n_checks++; if (o_data !== exp6 || o_co !== 6'd0) begin n_fail++; $display("FAIL bp_hold_c%0d: got co=%0d data=%h want co=0 data=%h", i, o_co, o_data, exp6); end
      tick();
    end
    o_ready = 1'b1; tick();
    n_checks++; if ({fetch_req, co_idx} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL bp_release: got req=%b co=%0d want 1 1", fetch_req, co_idx); end
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_abort: got busy=%b want 0", busy); end
  endtask

  task automatic test_fetch_delay();
    bit ok;
    accs_t exp6 = accs_mul(6);
    sel = 2'd0; o_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      core_sum = sums_mul(99);
      core_end = (i % 2 == 0);
      n_checks++; if ({fetch_req, core_en} !== 2'b10) begin n_fail++; $display("FAIL fd_wait_c%0d: got req/en=%b want 10", i, {fetch_req, core_en}); end
      tick();
    end
    core_end = 1'b0;
    n_checks++; if ({fetch_req, core_en} !== 2'b10) begin n_fail++; $display("FAIL fd_no_capture: got req/en=%b want 10", {fetch_req, core_en}); end
    fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
    n_checks++; if (core_en !== 1'b1) begin n_fail++; $display("FAIL fd_core_en: got %b want 1", core_en); end
    core_sum = sums_mul(1); core_end = 1'b1; tick(); core_end = 1'b0; tick();
    do_pass(sums_mul(10), ok);
    do_pass(sums_mul(-5), ok);
    n_checks++; if (!ok || o_data !== exp6) begin n_fail++; $display("FAIL fd_result: ok=%b got %h want %h", ok, o_data, exp6); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    accs_t exp6 = accs_mul(6);
    sel = 2'd0; o_ready = 1'b1;
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    n_checks++; if ({busy, fetch_req} !== 2'b00) begin n_fail++; $display("FAIL ab_prio: got busy/req=%b want 00", {busy, fetch_req}); end
    start = 1'b1; tick(); start = 1'b0;
    do_pass(sums_mul(3), ok);
    fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
    n_checks++; if ({core_en, ci_idx, co_idx} !== {1'b1, 4'd1, 6'd0}) begin n_fail++; $display("FAIL ab_run: got en=%b ci=%0d co=%0d want 1 1 0", core_en, ci_idx, co_idx); end
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++; if ({busy, core_en, fetch_req, ci_idx} !== 7'd0) begin n_fail++; $display("FAIL ab_idle: got busy=%b en=%b req=%b ci=%0d want 0 0 0 0", busy, core_en, fetch_req, ci_idx); end
    n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL ab_clear: got %h want 0", o_data); end
    start = 1'b1; tick(); start = 1'b0;
    for (int co = 0; co < 2; co++) begin
      do_pass(sums_mul(1), ok);
      do_pass(sums_mul(10), ok);
      do_pass(sums_mul(-5), ok);
      n_checks++; if (o_valid !== 1'b1 || o_data !== exp6 || o_co !== 6'(co)) begin n_fail++; $display("FAIL ab_rerun_co%0d: got valid=%b co=%0d data=%h want 1 %0d %h", co, o_valid, o_co, o_data, co, exp6); end
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ab_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_reset_mid_out();
    bit    ok;
    sums_t s;
    accs_t e;
    sel = 2'd0; o_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    do_pass(sums_mul(1), ok);
    do_pass(sums_mul(10), ok);
    do_pass(sums_mul(-5), ok);
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_out: got %b want 1", o_valid); end
    rstn = 1'b0; tick(); rstn = 1'b1;
    n_checks++; if ({busy, o_valid, fetch_req, core_en, done} !== 5'd0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 00000", {busy, o_valid, fetch_req, core_en, done}); end
    n_checks++; if (o_data !== '0 || o_co !== 6'd0) begin n_fail++; $display("FAIL rst_data: got co=%0d data=%h want 0", o_co, o_data); end
    s[0] = 16'h8000; e[0] = 20'hF8000;
    s[1] = 16'h7FFF; e[1] = 20'h07FFF;
    s[2] = 16'hFFFF; e[2] = 20'hFFFFF;
    s[3] = 16'h1234; e[3] = 20'h01234;
    s[4] = 16'hEDCC; e[4] = 20'hFEDCC;
    s[5] = 16'h0001; e[5] = 20'h00001;
    s[6] = 16'hFF00; e[6] = 20'hFFF00;
    s[7] = 16'h0000; e[7] = 20'h00000;
    sel = 2'd2; o_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    do_pass(s, ok);
    n_checks++; if (!ok || o_valid !== 1'b1) begin n_fail++; $display("FAIL cin1_valid: ok=%b got %b want 1", ok, o_valid); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (o_data[k] !== e[k]) begin n_fail++; $display("FAIL cin1_lane%0d: got %h want %h", k + 1, o_data[k], e[k]); end
    end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cin1_done: got %b want 1", done); end
    tick();
    n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL cin1_idle: got done/busy=%b want 00", {done, busy}); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_extreme();
    test_backpressure();
    test_fetch_delay();
    test_abort();
    test_reset_mid_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
